kodon_paketleyici: RTL
======================

// Module: kodon_paketleyici
// PURPOSE
//  Front-end / score sink for the codon comparator (kodon_kontrol).
//  - Packs two serial nucleotide streams into 6-bit codon pairs and presents them to the comparator.
//  - Collects the comparator's 2-bit skor and accumulates results over a fixed-length codon run.
//  - Reports total score, full-match count and zero-match count when the run is finished.
// PARAMETERS
//  KODON_SAYISI  8  codons per run (>=1)
//  SKOR_GECIKME  1  clk edges from codon load until comparator skor is valid (kodon_kontrol = 1)
//  derived localparams:
//    SKOR_W = $clog2(3*KODON_SAYISI+1)
//    SAY_W  = $clog2(KODON_SAYISI+1)
// PORTS
//  clk             in   1       system clock; all state changes on the rising edge
//  rst_n           in   1       asynchronous, active-low reset
//  basla           in   1       run start pulse
//  nuk_gecerli     in   1       nukleotid1/nukleotid2 valid
//  nukleotid1      in   2       sequence-1 nucleotide (A=00 C=01 G=10 T=11)
//  nukleotid2      in   2       sequence-2 nucleotide
//  hazir           out  1       nucleotide pair is accepted when hazir & nuk_gecerli
//  kodon1          out  6       packed codon to comparator; first nucleotide in [5:4]
//  kodon2          out  6       packed codon to comparator; first nucleotide in [5:4]
//  kodon_gecerli   out  1       one-cycle pulse, high in the cycle after the codon load edge
//  skor            in   2       comparator score, 0..3
//  toplam_skor     out  SKOR_W  running score sum
//  tam_eslesme     out  SAY_W   number of codons with skor==3
//  sifir_eslesme   out  SAY_W   number of codons with skor==0
//  bitti           out  1       run complete; held until the next basla or reset
// BEHAVIOUR
//  Reset (asynchronous, rst_n=0):
//    - all outputs 0, state BOS, nucleotide index 0, codon counter 0, wait counter 0
//  States: BOS -> TOPLA -> BEKLE -> (TOPLA | BITTI); BITTI -> TOPLA on basla.
//  BOS:
//    - hazir=0
//    - on basla: clear toplam_skor, tam_eslesme, sifir_eslesme and bitti; go to TOPLA
//  TOPLA (hazir=1):
//    - each accepted pair shifts into the packers at index 0,1,2
//    - on the 3rd accept, kodon1/kodon2 load the complete codon on the same edge
//    - kodon_gecerli=1 for the next cycle; wait counter is cleared; go to BEKLE
//    - nuk_gecerli=0 cycles are gaps: no state change
//  BEKLE (hazir=0):
//    - kodon1/kodon2 held stable
//    - wait counter increments each edge
//    - skor is sampled on the edge where wait counter == SKOR_GECIKME, i.e. load edge + SKOR_GECIKME+1:
//        toplam_skor += skor
//        tam_eslesme++   if skor==3
//        sifir_eslesme++ if skor==0
//    - same edge: if codon counter == KODON_SAYISI-1, go to BITTI and set bitti=1;
//      else increment codon counter and go to TOPLA
//  BITTI (hazir=0):
//    - results held
//    - on basla: clear results and bitti, codon counter 0, go to TOPLA
//  basla in TOPLA/BEKLE: ignored.
//  Pairs offered while hazir=0: not consumed; the source holds them.
//  Width rule: sums never overflow by construction (max 3*KODON_SAYISI fits SKOR_W).
//  kodon1/kodon2 keep the last codon after the run; they are only updated on a 3rd accept.
//  Reset mid-run: immediate return to the reset state; partial codons and partial sums are discarded.
// STRUCTURE
//  Shared package dna_pkg:
//    - nucleotide codes NUK_A/C/G/T, KODON_W=6, SKOR_MAX=2'b11
//    - state encoding BOS/TOPLA/BEKLE/BITTI
//  Sub-module kodon_kaydirici:
//    - 2-bit x3 shift/pack register with an index counter
//    - instantiated once per sequence
//    - outputs 'tam' (third nucleotide accepted) and the 6-bit codon
//  Top level: FSM, wait counter, codon counter, accumulators.
// TESTING (bench instantiates kodon_kontrol as the comparator; defaults)
//  1. rst_n=0 mid-idle:
//     - all outputs 0, hazir=0
//     - after release, basla -> hazir=1 on the next cycle
//  2. Feed A,C,G on both streams:
//     - kodon1=kodon2=6'b000110 with a one-cycle kodon_gecerli
//     - hazir low for 2 cycles
//     - toplam_skor=3, tam_eslesme=1
//  3. Eight codons ACG vs ACG -> toplam_skor=24, tam_eslesme=8, sifir_eslesme=0, bitti=1 held
//  4. Eight codons AAA vs CCC -> toplam_skor=0, sifir_eslesme=8, bitti=1
//  5. Mixed run, skor 0,1,2,3 each twice:
//     - random nuk_gecerli gaps, valid held during hazir=0
//     - toplam_skor=12, tam=2, sifir=2; no pair lost or duplicated
//  6. Reset mid-run:
//     - rst_n=0 after 4 codons -> all outputs 0
//     - basla during TOPLA ignored
//     - a fresh 8-codon run completes with the correct totals

Source files
------------

// File: rtl/dna_pkg.sv
// Shared nucleotide codes, codon width and FSM encoding for the codon packer.
`default_nettype none

package dna_pkg;

  localparam logic [1:0] NUK_A    = 2'b00;
  localparam logic [1:0] NUK_C    = 2'b01;
  localparam logic [1:0] NUK_G    = 2'b10;
  localparam logic [1:0] NUK_T    = 2'b11;
  localparam int         KODON_W  = 6;
  localparam logic [1:0] SKOR_MAX = 2'b11;

  typedef enum logic [1:0] {
    BOS   = 2'd0,
    TOPLA = 2'd1,
    BEKLE = 2'd2,
    BITTI = 2'd3
  } durum_t;

endpackage

`default_nettype wire

// File: rtl/kodon_kaydirici.sv
// Packs three accepted 2-bit nucleotides into one 6-bit codon, first nucleotide in [5:4].
`default_nettype none

module kodon_kaydirici
  import dna_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_kabul,
  input  logic [1:0]         i_nuk,
  output logic               o_tam,
  output logic [KODON_W-1:0] o_kodon
);

  logic [1:0] r_indeks;
  logic [3:0] r_kayit;

  // The codon is presented combinationally so the caller can load it on the 3rd accept edge.
  assign o_tam   = i_kabul && (r_indeks == 2'd2);
  assign o_kodon = {r_kayit, i_nuk};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_indeks <= 2'd0;
      r_kayit  <= 4'd0;
    end else if (i_kabul) begin
      r_kayit  <= {r_kayit[1:0], i_nuk};
      r_indeks <= (r_indeks == 2'd2) ? 2'd0 : r_indeks + 2'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/kodon_paketleyici.sv
// Codon front-end and score sink: packs nucleotide pairs, feeds the comparator, accumulates skor.
`default_nettype none

module kodon_paketleyici
  import dna_pkg::*;
#(
  parameter  int KODON_SAYISI = 8,
  parameter  int SKOR_GECIKME = 1,
  localparam int SKOR_W       = $clog2(3*KODON_SAYISI+1),
  localparam int SAY_W        = $clog2(KODON_SAYISI+1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               basla,
  input  logic               nuk_gecerli,
  input  logic [1:0]         nukleotid1,
  input  logic [1:0]         nukleotid2,
  output logic               hazir,
  output logic [KODON_W-1:0] kodon1,
  output logic [KODON_W-1:0] kodon2,
  output logic               kodon_gecerli,
  input  logic [1:0]         skor,
  output logic [SKOR_W-1:0]  toplam_skor,
  output logic [SAY_W-1:0]   tam_eslesme,
  output logic [SAY_W-1:0]   sifir_eslesme,
  output logic               bitti
);

  localparam int BEK_W = (SKOR_GECIKME < 1) ? 1 : $clog2(SKOR_GECIKME+1);

  durum_t             r_durum, w_sonraki;
  logic [BEK_W-1:0]   r_bekle;
  logic [SAY_W-1:0]   r_kodon_say;
  logic               w_kabul, w_tam1, w_tam2, w_tam;
  logic               w_ornekle, w_son, w_basla_al;
  logic [KODON_W-1:0] w_kodon1, w_kodon2;

  assign hazir      = (r_durum == TOPLA);
  assign w_kabul    = hazir && nuk_gecerli;
  assign w_tam      = w_tam1 && w_tam2;
  assign w_ornekle  = (r_durum == BEKLE) && (r_bekle == BEK_W'(SKOR_GECIKME));
  assign w_son      = (r_kodon_say == SAY_W'(KODON_SAYISI-1));
  assign w_basla_al = basla && ((r_durum == BOS) || (r_durum == BITTI));

  kodon_kaydirici u_kaydirici1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_kabul (w_kabul),
    .i_nuk   (nukleotid1),
    .o_tam   (w_tam1),
    .o_kodon (w_kodon1)
  );

  kodon_kaydirici u_kaydirici2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_kabul (w_kabul),
    .i_nuk   (nukleotid2),
    .o_tam   (w_tam2),
    .o_kodon (w_kodon2)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_durum <= BOS;
    else        r_durum <= w_sonraki;
  end

  always_comb begin
    w_sonraki = r_durum;
    case (r_durum)
      BOS, BITTI: if (basla)     w_sonraki = TOPLA;
      TOPLA:      if (w_tam)     w_sonraki = BEKLE;
      BEKLE:      if (w_ornekle) w_sonraki = w_son ? BITTI : TOPLA;
      default:                   w_sonraki = BOS;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kodon1        <= '0;
      kodon2        <= '0;
      kodon_gecerli <= 1'b0;
      r_bekle       <= '0;
      r_kodon_say   <= '0;
      toplam_skor   <= '0;
      tam_eslesme   <= '0;
      sifir_eslesme <= '0;
      bitti         <= 1'b0;
    end else begin
      kodon_gecerli <= w_tam;
      if (w_tam) begin
        kodon1  <= w_kodon1;
        kodon2  <= w_kodon2;
        r_bekle <= '0;
      end else if (r_durum == BEKLE) begin
        r_bekle <= r_bekle + BEK_W'(1);
      end
      if (w_basla_al) begin
        toplam_skor   <= '0;
        tam_eslesme   <= '0;
        sifir_eslesme <= '0;
        bitti         <= 1'b0;
        r_kodon_say   <= '0;
      end
      // The comparator result for the held codon is valid exactly on this edge.
      if (w_ornekle) begin
        toplam_skor <= toplam_skor + SKOR_W'(skor);
        if (skor == SKOR_MAX) tam_eslesme   <= tam_eslesme + SAY_W'(1);
        if (skor == 2'b00)    sifir_eslesme <= sifir_eslesme + SAY_W'(1);
        if (w_son) bitti       <= 1'b1;
        else       r_kodon_say <= r_kodon_say + SAY_W'(1);
      end
    end
  end

endmodule

`default_nettype wire
